// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a combinational ALU with a valid/ready result port
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_err,
  output logic             busy,
  output logic [AW:0]      fifo_count
);
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  state_t state, state_nx;
  logic [2*WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0] head_op;
  logic [WIDTH-1:0] head_a, head_b, res;
  logic push, pop, issue, flush, def_op;
  assign {head_op, head_a, head_b} = mem[rd_ptr];
  assign in_ready = fifo_count != (AW+1)'(DEPTH);
  assign push = in_valid & in_ready;
  assign pop = state == IDLE && fifo_count != '0;
  assign issue = pop && head_op != OP_NOP;
  assign flush = state == EXEC && alu_op == OP_RST;
  assign def_op = alu_op inside {4'h0, 4'h1, 4'h4, 4'h5, [4'h8:4'hD]};
  assign res = (flush || !def_op) ? '0 : alu_result;
  assign busy = state != IDLE || fifo_count != '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (issue ? EXEC : IDLE) :
               state == EXEC ? OUT : (out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_op, in_a, in_b};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // a flush skips the read pointer past every stored entry but keeps a same-cycle push
      rd_ptr     <= flush ? wr_ptr : pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count <= flush ? (AW+1)'(push) : fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (issue) begin
        alu_a  <= head_a;
        alu_b  <= head_b;
        alu_op <= head_op;
      end
      if (state == EXEC) begin
        out_valid  <= 1'b1;
        out_result <= res;
        out_zero   <= res == '0;
        out_neg    <= res[WIDTH-1];
        out_err    <= !def_op;
      end else if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
